// File: rtl/pc_sequencer_pkg.sv
// Shared state encodings and opcode constants for the program-counter sequencer.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StExec  = 3'd2,
        StRedir = 3'd3,
        StHalt  = 3'd4
    } pc_state_e;

    localparam logic [3:0] OpJmp  = 4'hC;
    localparam logic [3:0] OpBeq  = 4'hD;
    localparam logic [3:0] OpBne  = 4'hE;
    localparam logic [3:0] OpHalt = 4'hF;

endpackage

// File: rtl/sign_extend_shifter.sv
// Sign-extends either the wide jump field or the narrow branch field and scales it
// to a byte offset.
module sign_extend_shifter #(
    parameter int unsigned InW   = 12,
    parameter int unsigned BrW   = 8,
    parameter int unsigned OutW  = 16,
    parameter int unsigned Shift = 1
) (
    input  logic [InW-1:0]  ext_in,
    input  logic            ext_jump,
    output logic [OutW-1:0] ext_out
);

    logic [OutW-1:0] wide_jmp;
    logic [OutW-1:0] wide_br;

    assign wide_jmp = {{(OutW - InW){ext_in[InW-1]}}, ext_in};
    assign wide_br  = {{(OutW - BrW){ext_in[BrW-1]}}, ext_in[BrW-1:0]};
    assign ext_out  = (ext_jump ? wide_jmp : wide_br) << Shift;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: fetches instructions, hands them to the datapath and
// redirects the PC on jumps and taken branches.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        zero_flag,
    output logic        redirect,
    output logic        halted
);

    pc_state_e   state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic        imem_req_q, instr_valid_q, redirect_q, halted_q;

    logic [3:0]  op;
    logic [15:0] ext_out;
    logic [15:0] target;
    logic        taken;

    assign op = instr_q[15:12];

    sign_extend_shifter #(12, 8, 16, 1) u_ext (
        .ext_in   (instr_q[11:0]),
        .ext_jump (op == OpJmp),
        .ext_out  (ext_out)
    );

    assign target = pc_q + PC_STEP + ext_out;
    assign taken  = (op == OpJmp) || ((op == OpBeq) && zero_flag) ||
                    ((op == OpBne) && !zero_flag);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                if (imem_ready) begin
                    instr_d = imem_data;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (exec_done) begin
                    if (taken) begin
                        pc_d    = target;
                        state_d = StRedir;
                    end else if (op == OpHalt) begin
                        state_d = StHalt;
                    end else begin
                        pc_d    = pc_q + PC_STEP;
                        state_d = StFetch;
                    end
                end
            end
            StRedir: state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            instr_q       <= 16'h0000;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            redirect_q    <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            imem_req_q    <= (state_d == StFetch);
            instr_valid_q <= (state_d == StExec);
            redirect_q    <= (state_d == StRedir);
            halted_q      <= (state_d == StHalt);
        end
    end

    assign imem_addr   = pc_q;
    assign imem_req    = imem_req_q;
    assign instr_out   = instr_q;
    assign instr_valid = instr_valid_q;
    assign redirect    = redirect_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised bench for pc_sequencer against an instruction-level reference model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        exec_done = 1'b0;
    logic        zero_flag = 1'b0;
    logic        redirect;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [65536];
    logic [15:0] m_pc;

    pc_sequencer u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .imem_data   (imem_data),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .zero_flag   (zero_flag),
        .redirect    (redirect),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One full fetch/execute; called at a negedge while the DUT is fetching.
    task automatic run_instr(input logic zf, input int rdly, input int ddly);
        logic [15:0] ins;
        logic [3:0]  op;
        logic        taken;
        int          f;
        int          nxt;
        int          n;
        n = 0;
        while (!imem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("fetch_req", {15'd0, imem_req}, 16'd1);
        check_eq("fetch_addr", imem_addr, m_pc);
        ins = mem[m_pc];
        for (int i = 0; i < rdly; i++) begin
            imem_ready = 1'b0;
            exec_done  = 1'($urandom_range(0, 1));
            start      = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("req_hold", {15'd0, imem_req}, 16'd1);
            check_eq("addr_hold", imem_addr, m_pc);
        end
        imem_ready = 1'b1;
        imem_data  = ins;
        exec_done  = 1'($urandom_range(0, 1));
        @(negedge clk);
        imem_ready = 1'b0;
        imem_data  = 16'($urandom);
        start      = 1'b0;
        check_eq("exec_valid", {15'd0, instr_valid}, 16'd1);
        check_eq("exec_instr", instr_out, ins);
        check_eq("exec_noreq", {15'd0, imem_req}, 16'd0);
        for (int i = 0; i < ddly; i++) begin
            exec_done  = 1'b0;
            imem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("valid_hold", {15'd0, instr_valid}, 16'd1);
        end
        exec_done  = 1'b1;
        zero_flag  = zf;
        imem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        exec_done  = 1'b0;
        imem_ready = 1'($urandom_range(0, 1));

        op    = ins[15:12];
        taken = 1'b0;
        nxt   = int'(m_pc) + 2;
        if (op == 4'hC) begin
            f = int'(ins[11:0]);
            if (f >= 2048) f -= 4096;
            nxt   = int'(m_pc) + 2 + 2 * f;
            taken = 1'b1;
        end else if (op == 4'hD || op == 4'hE) begin
            f = int'(ins[7:0]);
            if (f >= 128) f -= 256;
            taken = (op == 4'hD) ? zf : !zf;
            if (taken) nxt = int'(m_pc) + 2 + 2 * f;
        end

        if (op == 4'hF) begin
            check_eq("halt_flag", {15'd0, halted}, 16'd1);
            check_eq("halt_noreq", {15'd0, imem_req}, 16'd0);
            check_eq("halt_novalid", {15'd0, instr_valid}, 16'd0);
            check_eq("halt_noredir", {15'd0, redirect}, 16'd0);
        end else begin
            m_pc = 16'(nxt);
            check_eq("redir_pulse", {15'd0, redirect}, {15'd0, taken});
            check_eq("next_addr", imem_addr, m_pc);
            if (taken) begin
                check_eq("redir_noreq", {15'd0, imem_req}, 16'd0);
                @(negedge clk);
                imem_ready = 1'b0;
                check_eq("redir_once", {15'd0, redirect}, 16'd0);
            end
            check_eq("refetch_req", {15'd0, imem_req}, 16'd1);
            imem_ready = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] w;
        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF) w[15:12] = 4'h0;
            mem[i] = w;
        end
        mem[16'h0000] = 16'h1234;
        mem[16'h0002] = 16'hC006;
        mem[16'h0010] = 16'hC003;
        mem[16'h0018] = 16'hC003;
        mem[16'h0020] = 16'hD0FE;
        mem[16'h001E] = 16'hC000;
        mem[16'h0022] = 16'hC006;
        mem[16'h0030] = 16'hE081;
        mem[16'hFF34] = 16'hC064;
        mem[16'hFFFE] = 16'h1111;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_addr", imem_addr, 16'h0000);
        check_eq("rst_req", {15'd0, imem_req}, 16'd0);
        check_eq("rst_valid", {15'd0, instr_valid}, 16'd0);
        check_eq("rst_instr", instr_out, 16'h0000);
        check_eq("rst_redir", {15'd0, redirect}, 16'd0);
        check_eq("rst_halt", {15'd0, halted}, 16'd0);
        rst = 1'b0;
        imem_ready = 1'b1;
        exec_done  = 1'b1;
        @(negedge clk);
        check_eq("idle_noreq", {15'd0, imem_req}, 16'd0);
        imem_ready = 1'b0;
        exec_done  = 1'b0;
        m_pc  = 16'h0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        run_instr(1'b0, 0, 0);
        check_eq("seq_0002", imem_addr, 16'h0002);
        run_instr(1'b0, 1, 0);
        run_instr(1'b1, 0, 1);
        check_eq("jmp_0018", imem_addr, 16'h0018);
        run_instr(1'b0, 0, 0);
        run_instr(1'b1, 0, 0);
        check_eq("beq_t_001e", imem_addr, 16'h001E);
        run_instr(1'b0, 0, 0);
        run_instr(1'b0, 0, 2);
        check_eq("beq_nt_0022", imem_addr, 16'h0022);
        run_instr(1'b0, 0, 0);
        run_instr(1'b0, 2, 0);
        check_eq("bne_ff34", imem_addr, 16'hFF34);
        run_instr(1'b1, 0, 0);
        run_instr(1'b1, 0, 0);
        check_eq("wrap_0000", imem_addr, 16'h0000);
        run_instr(1'b0, 5, 0);

        // Reset in the middle of an execute
        imem_ready = 1'b1;
        imem_data  = mem[m_pc];
        @(negedge clk);
        imem_ready = 1'b0;
        check_eq("pre_rst_valid", {15'd0, instr_valid}, 16'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_valid", {15'd0, instr_valid}, 16'd0);
        check_eq("async_addr", imem_addr, 16'h0000);
        check_eq("async_req", {15'd0, imem_req}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_idle", {15'd0, imem_req}, 16'd0);
        m_pc  = 16'h0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        for (int k = 0; k < 150; k++) begin
            run_instr(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        mem[m_pc] = 16'hF000;
        run_instr(1'($urandom_range(0, 1)), 1, 1);
        for (int i = 0; i < 4; i++) begin
            start      = 1'b1;
            imem_ready = 1'($urandom_range(0, 1));
            exec_done  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("halt_stay", {15'd0, halted}, 16'd1);
            check_eq("halt_stay_req", {15'd0, imem_req}, 16'd0);
        end
        start      = 1'b0;
        imem_ready = 1'b0;
        exec_done  = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("halt_cleared", {15'd0, halted}, 16'd0);
        check_eq("halt_rst_addr", imem_addr, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
